// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared command field layout, state encoding and helpers
package audio_pkg;

    localparam int CMD_FREQ_LSB = 0;
    localparam int CMD_FREQ_MSB = 15;
    localparam int CMD_DUR_LSB  = 16;
    localparam int CMD_DUR_MSB  = 27;
    localparam int CMD_DBL_BIT  = 28;
    localparam int CMD_W        = 29;

    localparam logic [15:0] F_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    // Second voice sits an octave up; saturate rather than wrap past 16 bits.
    function automatic logic [15:0] sat_double(input logic [15:0] f);
        logic [16:0] w_dbl;
        w_dbl = {f, 1'b0};
        return w_dbl[16] ? F_MAX : w_dbl[15:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush and show-ahead head entry
module sync_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_do_rd;
    logic             w_do_wr;

    assign full    = (r_level == (AW+1)'(DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign dout    = r_mem[r_rptr];
    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign w_do_rd = rd && !empty;
    assign w_do_wr = wr && (!full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr && !flush && !rst) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - buffers MMIO note commands and plays them to the I2S stage
module note_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int DEPTH  = 16,
    parameter int GAP_MS = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [31:0]              wr_data,
    input  logic                     stop,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     busy,
    output logic                     en,
    output logic [15:0]              f_1,
    output logic [15:0]              f_2,
    output logic                     double
);

    localparam int          TICK_DIV = CLK_HZ / 1000;
    localparam int          PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [11:0] GAP_LD   = 12'(GAP_MS);

    state_t             r_state;
    state_t             w_next_state;
    logic [PW-1:0]      r_presc;
    logic [PW-1:0]      w_presc_d;
    logic [11:0]        r_ms;
    logic [11:0]        w_ms_d;
    logic               r_en,  w_en_d;
    logic [15:0]        r_f1,  w_f1_d;
    logic [15:0]        r_f2,  w_f2_d;
    logic               r_dbl, w_dbl_d;
    logic               r_busy;
    logic               r_ovf;

    logic [CMD_W-1:0]   w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic [15:0]        w_freq;
    logic [11:0]        w_dur;
    logic               w_dbl;
    logic               w_tick;
    logic               w_last;
    logic               w_unused;

    assign w_unused = ^wr_data[31:29];
    assign w_pop    = (r_state == S_LOAD);
    assign w_freq   = w_head[CMD_FREQ_MSB:CMD_FREQ_LSB];
    assign w_dur    = w_head[CMD_DUR_MSB:CMD_DUR_LSB];
    assign w_dbl    = w_head[CMD_DBL_BIT];
    assign w_tick   = (r_presc == PW'(TICK_DIV - 1));
    assign w_last   = w_tick && (r_ms == 12'd1);

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (stop),
        .wr    (wr_en),
        .rd    (w_pop),
        .din   (wr_data[CMD_W-1:0]),
        .dout  (w_head),
        .level (level),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (!w_empty) w_next_state = S_LOAD;
            S_LOAD: w_next_state = (w_dur == '0) ? S_IDLE : S_PLAY;
            S_PLAY: if (w_last) w_next_state = (GAP_MS > 0) ? S_GAP : S_IDLE;
            S_GAP:  if (w_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Counters restart on every PLAY/GAP entry so each note is exact to the cycle.
    always_comb begin
        w_en_d    = r_en;
        w_f1_d    = r_f1;
        w_f2_d    = r_f2;
        w_dbl_d   = r_dbl;
        w_presc_d = r_presc;
        w_ms_d    = r_ms;
        case (r_state)
            S_LOAD: begin
                if (w_dur != '0) begin
                    w_en_d    = (w_freq != '0);
                    w_f1_d    = w_freq;
                    w_dbl_d   = w_dbl;
                    w_f2_d    = w_dbl ? sat_double(w_freq) : '0;
                    w_presc_d = '0;
                    w_ms_d    = w_dur;
                end
            end
            S_PLAY, S_GAP: begin
                if (w_tick) begin
                    w_presc_d = '0;
                    w_ms_d    = r_ms - 12'd1;
                end else begin
                    w_presc_d = r_presc + 1'b1;
                end
                if (w_last) begin
                    w_en_d  = 1'b0;
                    w_f1_d  = '0;
                    w_f2_d  = '0;
                    w_dbl_d = 1'b0;
                    if (r_state == S_PLAY) begin
                        w_ms_d = GAP_LD;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            r_en    <= 1'b0;
            r_f1    <= '0;
            r_f2    <= '0;
            r_dbl   <= 1'b0;
            r_presc <= '0;
            r_ms    <= '0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_en    <= w_en_d;
            r_f1    <= w_f1_d;
            r_f2    <= w_f2_d;
            r_dbl   <= w_dbl_d;
            r_presc <= w_presc_d;
            r_ms    <= w_ms_d;
            r_busy  <= (w_next_state != S_IDLE);
            if (wr_en && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign full   = w_full;
    assign ovf    = r_ovf;
    assign busy   = r_busy;
    assign en     = r_en;
    assign f_1    = r_f1;
    assign f_2    = r_f2;
    assign double = r_dbl;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer
module tb_note_sequencer;

    localparam int CLK_HZ = 4000;
    localparam int DEPTH  = 4;
    localparam int GAP_MS = 1;
    localparam int TD     = CLK_HZ / 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        stop;
    logic        full;
    logic [2:0]  level;
    logic        ovf;
    logic        busy;
    logic        en;
    logic [15:0] f_1;
    logic [15:0] f_2;
    logic        double;

    typedef struct {
        int          seg_len;
        int          en_cyc;
        int          f1_cyc;
        logic [15:0] f1;
        logic [15:0] f2;
        logic        dbl;
    } note_t;

    note_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    seg_count = 0;
    bit    mon_discard = 1'b0;
    int    seg_before;

    note_sequencer #(
        .CLK_HZ (CLK_HZ),
        .DEPTH  (DEPTH),
        .GAP_MS (GAP_MS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .stop    (stop),
        .full    (full),
        .level   (level),
        .ovf     (ovf),
        .busy    (busy),
        .en      (en),
        .f_1     (f_1),
        .f_2     (f_2),
        .double  (double)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic logic [31:0] cmd(input logic [15:0] f, input logic [11:0] d, input logic b);
        return {3'b000, b, d, f};
    endfunction

    // Hand-computed f2 is supplied by the caller; timing follows from dur and TICK_DIV.
    task automatic push_note(input logic [15:0] f, input int dur, input logic b, input logic [15:0] f2_exp);
        note_t n;
        n.seg_len = (dur == 0) ? 1 : 1 + dur * TD + GAP_MS * TD;
        n.en_cyc  = (dur != 0 && f != 0) ? dur * TD : 0;
        n.f1_cyc  = n.en_cyc;
        n.f1      = (dur != 0) ? f : 16'd0;
        n.f2      = (dur != 0) ? f2_exp : 16'd0;
        n.dbl     = (dur != 0) ? b : 1'b0;
        exp_q.push_back(n);
    endtask

    task automatic write1(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && level == 0 && exp_q.size() == 0) break;
        end
        chk(name, (i < max_cyc), 1);
    endtask

    task automatic wait_en(input string name, input logic val, input int max_cyc);
        for (int i = 0; i < max_cyc && en !== val; i++) @(negedge clk);
        chk(name, en, val);
    endtask

    // Monitor: one record per busy segment (LOAD + PLAY + GAP).
    initial begin
        bit          in_seg;
        int          len, enc, f1c;
        logic [15:0] cf1, cf2;
        logic        cdbl;
        note_t       e;
        in_seg = 0;
        len = 0; enc = 0; f1c = 0; cf1 = 0; cf2 = 0; cdbl = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (!in_seg) begin
                    in_seg = 1;
                    len = 0; enc = 0; f1c = 0; cf1 = 0; cf2 = 0; cdbl = 0;
                end
                len++;
                if (en === 1'b1) enc++;
                if (f_1 != 0) f1c++;
                if (len == 2) begin
                    cf1 = f_1; cf2 = f_2; cdbl = double;
                end
            end else if (in_seg) begin
                in_seg = 0;
                seg_count++;
                if (mon_discard) begin
                    mon_discard = 1'b0;
                end else if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_note: got segment len %0d f_1 %0d expected no note", len, cf1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_seg_len", len, e.seg_len);
                    chk("sb_en_cycles", enc, e.en_cyc);
                    chk("sb_f1_cycles", f1c, e.f1_cyc);
                    chk("sb_f1", cf1, e.f1);
                    chk("sb_f2", cf2, e.f2);
                    chk("sb_double", cdbl, e.dbl);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; stop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_en", en, 0);
        chk("rst_f1", f_1, 0);
        chk("rst_f2", f_2, 0);
        chk("rst_double", double, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);

        // Single note: latency and length
        push_note(16'd440, 3, 1'b0, 16'd0);
        write1(cmd(16'd440, 12'd3, 1'b0));
        chk("t1_level1", level, 1);
        chk("t1_en_n1", en, 0);
        @(negedge clk);
        chk("t1_busy_load", busy, 1);
        chk("t1_en_load", en, 0);
        @(negedge clk);
        chk("t1_en", en, 1);
        chk("t1_f1", f_1, 440);
        chk("t1_level0", level, 0);
        wait_idle("t1_idle", 100);

        // Two-voice: saturated and unsaturated
        push_note(16'd40000, 1, 1'b1, 16'hFFFF);
        write1(cmd(16'd40000, 12'd1, 1'b1));
        wait_idle("t2a_idle", 100);
        push_note(16'd1000, 1, 1'b1, 16'd2000);
        write1(cmd(16'd1000, 12'd1, 1'b1));
        wait_idle("t2b_idle", 100);

        // Rest, then zero-duration command
        push_note(16'd0, 2, 1'b0, 16'd0);
        write1(cmd(16'd0, 12'd2, 1'b0));
        wait_idle("t3a_idle", 100);
        push_note(16'd300, 0, 1'b0, 16'd0);
        write1(cmd(16'd300, 12'd0, 1'b0));
        wait_idle("t3b_idle", 100);

        // Overflow: fill the FIFO while a long note plays
        push_note(16'd100, 5, 1'b0, 16'd0);
        write1(cmd(16'd100, 12'd5, 1'b0));
        wait_en("t4_en_seen", 1'b1, 20);
        for (int i = 1; i <= 4; i++) begin
            push_note(16'(200 + i), 1, 1'b0, 16'd0);
            write1(cmd(16'(200 + i), 12'd1, 1'b0));
        end
        chk("t4_full", full, 1);
        chk("t4_ovf_pre", ovf, 0);
        chk("t4_level4", level, 4);
        write1(cmd(16'd205, 12'd1, 1'b0));
        chk("t4_level_drop", level, 4);
        chk("t4_ovf", ovf, 1);
        wait_idle("t4_idle", 400);
        chk("t4_ovf_sticky", ovf, 1);

        // Stop mid-PLAY with two queued
        write1(cmd(16'd500, 12'd10, 1'b0));
        write1(cmd(16'd600, 12'd1, 1'b0));
        write1(cmd(16'd700, 12'd1, 1'b0));
        wait_en("t5_en_seen", 1'b1, 20);
        repeat (3) @(negedge clk);
        chk("t5_level2", level, 2);
        chk("t5_en_playing", en, 1);
        mon_discard = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t5_en", en, 0);
        chk("t5_f1", f_1, 0);
        chk("t5_level", level, 0);
        chk("t5_ovf", ovf, 0);
        chk("t5_busy", busy, 0);
        @(negedge clk);
        seg_before = seg_count;
        repeat (80) @(negedge clk);
        chk("t5_no_more_notes", seg_count, seg_before);
        chk("t5_discard_used", mon_discard, 0);

        // Reset during GAP with a simultaneous write
        write1(cmd(16'd800, 12'd1, 1'b0));
        wait_en("t6_en_seen", 1'b1, 20);
        wait_en("t6_gap_seen", 1'b0, 20);
        chk("t6_busy_gap", busy, 1);
        mon_discard = 1'b1;
        rst = 1'b1;
        wr_en = 1'b1;
        wr_data = cmd(16'd900, 12'd1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wr_en = 1'b0;
        chk("t6_en", en, 0);
        chk("t6_f1", f_1, 0);
        chk("t6_f2", f_2, 0);
        chk("t6_double", double, 0);
        chk("t6_busy", busy, 0);
        chk("t6_level", level, 0);
        chk("t6_full", full, 0);
        chk("t6_ovf", ovf, 0);
        @(negedge clk);
        seg_before = seg_count;
        repeat (40) @(negedge clk);
        chk("t6_write_dropped", seg_count, seg_before);
        chk("t6_level_after", level, 0);

        chk("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
